vx_warp_sched: RTL and testbench
================================

// Module: vx_warp_sched
// PURPOSE
//  Warp scheduler feeding fetch/decode. Holds per-warp PC, thread mask and state.
//  Picks one ready warp per cycle round-robin and issues {warp_num, PC, thread mask} to fetch.
//  Consumes decode-stage control (branch_stall, change_mask, wspawn, ebreak) and
//  execute-stage branch resolution to block, redirect, spawn or retire warps.
// PARAMETERS
//  NUM_WARPS    4             warps; power of 2, >=2; WB = log2(NUM_WARPS)
//  NUM_THREADS  4             threads per warp (mask width)
//  START_PC     32'h80000000  warp 0 PC after reset
// PORTS
//  clk              in   1    clock, all state on posedge
//  reset            in   1    asynchronous, active-low reset
//  in_stall         in   1    pipeline back-pressure; hold issue outputs
//  in_dec_valid     in   1    decode feedback below is valid this cycle
//  in_dec_warp_num  in   WB   warp the decoded instruction belongs to
//  in_branch_stall  in   1    decoded branch/jal/jalr/jalrs/jmprt: block warp
//  in_change_mask   in   1    load new thread mask for warp
//  in_thread_mask   in   NT   new mask when in_change_mask
//  in_wspawn        in   1    spawn all other warps
//  in_wspawn_pc     in   32   start PC for spawned warps
//  in_ebreak        in   1    terminate all warps
//  in_br_valid      in   1    execute-stage branch resolution valid
//  in_br_warp_num   in   WB   warp being resolved
//  in_br_taken      in   1    redirect required
//  in_br_dest       in   32   redirect target
//  out_valid        out  NT   thread mask of issued warp; 0 = bubble
//  out_PC           out  32   PC of issued instruction
//  out_warp_num     out  WB   issued warp
//  out_ebreak       out  1    sticky: all warps terminated
// BEHAVIOUR
//  - Per warp w: pc[w], mask[w], active[w], pending[w] (in decode), blocked[w] (awaiting branch).
//  - Reset (reset=0, async): warp0 active, pc=START_PC, mask=1 (thread 0); others inactive, pc=0,
//    mask=0; all pending/blocked=0; out_valid=0, out_PC=0, out_warp_num=0, out_ebreak=0; rr ptr=0.
//  - ready[w] = active & ~pending & ~blocked & ~out_ebreak.
//  - Issue (registered, 1-cycle): if ~in_stall, choose the first ready warp searching from
//    last_issued+1 upward, wrapping modulo NUM_WARPS. Next cycle: out_warp_num=w,
//    out_PC=pc[w], out_valid=mask[w]; pc[w]+=4 (mod 2^32); pending[w]=1; last_issued=w.
//    No ready warp -> out_valid=0, out_PC/out_warp_num hold, rr ptr holds.
//  - in_stall=1: all out_* hold, no selection, no pc increment. Feedback is still processed.
//  - Decode feedback when in_dec_valid for warp d: pending[d]=0; plus
//    in_branch_stall -> blocked[d]=1; in_change_mask -> mask[d]=in_thread_mask,
//    mask of 0 -> active[d]=0; in_wspawn -> every w!=d: active=1, pc=in_wspawn_pc, mask=1,
//    pending=blocked=0 (warp d unchanged); in_ebreak -> all active=0, out_ebreak=1 until reset.
//  - Resolution when in_br_valid for warp b: blocked[b]=0; in_br_taken -> pc[b]=in_br_dest,
//    else pc[b] unchanged (already +4).
//  - Same-cycle priority: ebreak > wspawn > resolution > decode mask/stall > issue increment.
//    Resolution redirect overrides issue +4 for the same warp. Issue never selects a warp whose
//    state is being written this cycle (uses pre-update ready).
//  - A warp has at most one instruction in decode; a single active warp issues every 2nd cycle.
//  - in_br_valid for an unblocked warp: pc update still applied, blocked stays 0.
//  - Reset asserted mid-operation: immediate return to reset state; no partial issue.
// TESTING
//  1 Release reset, no stall -> cycle1 out_valid=1 out_PC=80000000 warp0; decode ack each
//    issue -> PCs 80000000,80000004,... every 2nd cycle, bubbles between.
//  2 Warp0 decode in_branch_stall=1 -> no issue; in_br_valid taken dest=80000100 ->
//    next issue out_PC=80000100; not-taken -> next out_PC = previous+4.
//  3 wspawn pc=80000200 from warp0, NUM_WARPS=4 -> issue order 1,2,3,0 round-robin,
//    warps1-3 out_PC=80000200, out_valid=0001.
//  4 change_mask 1111 on warp0 -> next issue out_valid=1111; change_mask 0000 -> warp0 never
//    reissues; with no other warp out_valid=0 forever.
//  5 in_stall=1 for 3 cycles mid-stream -> outputs frozen, pc not advanced; resume at +4.
//  6 in_ebreak on warp2 -> out_ebreak=1 next cycle, out_valid=0 until reset; assert reset
//    mid-stream -> all outputs to reset values asynchronously, warp0 restarts at START_PC.

Source files
------------

// File: rtl/vx_warp_sched.sv
// Round-robin warp scheduler: per-warp PC/mask/state slots plus a registered
// one-cycle issue stage feeding fetch, steered by decode and branch feedback.

module vx_warp_slot #(
    parameter int          NUM_THREADS = 4,
    parameter logic [31:0] START_PC    = 32'h80000000,
    parameter bit          RST_ACTIVE  = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   issue,
    input  logic                   dec_hit,
    input  logic                   branch_stall,
    input  logic                   change_mask,
    input  logic [NUM_THREADS-1:0] thread_mask,
    input  logic                   spawn,
    input  logic [31:0]            spawn_pc,
    input  logic                   kill,
    input  logic                   br_hit,
    input  logic                   br_taken,
    input  logic [31:0]            br_dest,
    output logic [31:0]            pc,
    output logic [NUM_THREADS-1:0] mask,
    output logic                   active,
    output logic                   pending,
    output logic                   blocked
);

    // Later statements win: kill > spawn > resolution > decode > issue increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active  <= RST_ACTIVE;
            pc      <= RST_ACTIVE ? START_PC : 32'd0;
            mask    <= RST_ACTIVE ? NUM_THREADS'(1) : '0;
            pending <= 1'b0;
            blocked <= 1'b0;
        end else begin
            if (issue) begin
                pc      <= pc + 32'd4;
                pending <= 1'b1;
            end
            if (dec_hit) begin
                pending <= 1'b0;
                if (branch_stall)
                    blocked <= 1'b1;
                if (change_mask) begin
                    mask <= thread_mask;
                    if (thread_mask == '0)
                        active <= 1'b0;
                end
            end
            if (br_hit) begin
                blocked <= 1'b0;
                if (br_taken)
                    pc <= br_dest;
            end
            if (spawn) begin
                active  <= 1'b1;
                pc      <= spawn_pc;
                mask    <= NUM_THREADS'(1);
                pending <= 1'b0;
                blocked <= 1'b0;
            end
            if (kill)
                active <= 1'b0;
        end
    end

endmodule

module vx_warp_sched #(
    parameter int          NUM_WARPS   = 4,
    parameter int          NUM_THREADS = 4,
    parameter logic [31:0] START_PC    = 32'h80000000,
    localparam int         WB          = $clog2(NUM_WARPS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_stall,
    input  logic                   in_dec_valid,
    input  logic [WB-1:0]          in_dec_warp_num,
    input  logic                   in_branch_stall,
    input  logic                   in_change_mask,
    input  logic [NUM_THREADS-1:0] in_thread_mask,
    input  logic                   in_wspawn,
    input  logic [31:0]            in_wspawn_pc,
    input  logic                   in_ebreak,
    input  logic                   in_br_valid,
    input  logic [WB-1:0]          in_br_warp_num,
    input  logic                   in_br_taken,
    input  logic [31:0]            in_br_dest,
    output logic [NUM_THREADS-1:0] out_valid,
    output logic [31:0]            out_PC,
    output logic [WB-1:0]          out_warp_num,
    output logic                   out_ebreak
);

    logic [NUM_WARPS-1:0][31:0]            pc_w;
    logic [NUM_WARPS-1:0][NUM_THREADS-1:0] mask_w;
    logic [NUM_WARPS-1:0]                  active_w, pending_w, blocked_w;
    logic [NUM_WARPS-1:0]                  ready, issue_oh, dec_oh, br_oh, spawn_oh;
    logic [WB-1:0]                         last_issued, sel, idx;
    logic                                  found, kill, issue_en;

    assign kill     = in_dec_valid & in_ebreak;
    assign ready    = active_w & ~pending_w & ~blocked_w & {NUM_WARPS{~out_ebreak}};
    assign issue_en = ~in_stall & ~kill & found;

    // Search starts one past the last issued warp and wraps via WB-bit overflow.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NUM_WARPS; i++) begin
            idx = last_issued + WB'(i);
            if (!found && ready[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        issue_oh = '0;
        dec_oh   = '0;
        br_oh    = '0;
        if (issue_en)
            issue_oh[sel] = 1'b1;
        if (in_dec_valid)
            dec_oh[in_dec_warp_num] = 1'b1;
        if (in_br_valid)
            br_oh[in_br_warp_num] = 1'b1;
        spawn_oh = (in_dec_valid && in_wspawn) ? ~dec_oh : '0;
    end

    for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
        vx_warp_slot #(
            .NUM_THREADS (NUM_THREADS),
            .START_PC    (START_PC),
            .RST_ACTIVE  (w == 0)
        ) u_slot (
            .clk          (clk),
            .reset        (reset),
            .issue        (issue_oh[w]),
            .dec_hit      (dec_oh[w]),
            .branch_stall (in_branch_stall),
            .change_mask  (in_change_mask),
            .thread_mask  (in_thread_mask),
            .spawn        (spawn_oh[w]),
            .spawn_pc     (in_wspawn_pc),
            .kill         (kill),
            .br_hit       (br_oh[w]),
            .br_taken     (in_br_taken),
            .br_dest      (in_br_dest),
            .pc           (pc_w[w]),
            .mask         (mask_w[w]),
            .active       (active_w[w]),
            .pending      (pending_w[w]),
            .blocked      (blocked_w[w])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid    <= '0;
            out_PC       <= 32'd0;
            out_warp_num <= '0;
            out_ebreak   <= 1'b0;
            last_issued  <= '0;
        end else begin
            if (!in_stall) begin
                if (issue_en) begin
                    out_valid    <= mask_w[sel];
                    out_PC       <= pc_w[sel];
                    out_warp_num <= sel;
                    last_issued  <= sel;
                end else begin
                    out_valid <= '0;
                end
            end
            // Termination blanks issue immediately, even through a stall.
            if (kill || out_ebreak)
                out_valid <= '0;
            if (kill)
                out_ebreak <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vx_warp_sched.sv
// Directed plus randomized bench for vx_warp_sched against an array-based
// reference model of the per-warp scheduling rules.

module tb_vx_warp_sched;

    localparam int NW = 4;
    localparam int NT = 4;
    localparam int WB = 2;
    localparam logic [31:0] SPC = 32'h80000000;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_stall, in_dec_valid, in_branch_stall, in_change_mask;
    logic [WB-1:0] in_dec_warp_num, in_br_warp_num;
    logic [NT-1:0] in_thread_mask;
    logic          in_wspawn, in_ebreak, in_br_valid, in_br_taken;
    logic [31:0]   in_wspawn_pc, in_br_dest;
    logic [NT-1:0] out_valid;
    logic [31:0]   out_PC;
    logic [WB-1:0] out_warp_num;
    logic          out_ebreak;

    int n_tests = 0;
    int n_fail  = 0;

    // reference state
    logic [31:0]   m_pc[NW];
    logic [NT-1:0] m_mask[NW];
    bit            m_act[NW], m_pend[NW], m_blk[NW];
    logic [NT-1:0] m_ov;
    logic [31:0]   m_opc;
    int            m_ow, m_last;
    bit            m_ebk;

    vx_warp_sched #(.NUM_WARPS(NW), .NUM_THREADS(NT), .START_PC(SPC)) dut (
        .clk(clk), .reset(reset), .in_stall(in_stall), .in_dec_valid(in_dec_valid),
        .in_dec_warp_num(in_dec_warp_num), .in_branch_stall(in_branch_stall),
        .in_change_mask(in_change_mask), .in_thread_mask(in_thread_mask),
        .in_wspawn(in_wspawn), .in_wspawn_pc(in_wspawn_pc), .in_ebreak(in_ebreak),
        .in_br_valid(in_br_valid), .in_br_warp_num(in_br_warp_num),
        .in_br_taken(in_br_taken), .in_br_dest(in_br_dest),
        .out_valid(out_valid), .out_PC(out_PC), .out_warp_num(out_warp_num),
        .out_ebreak(out_ebreak)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int w = 0; w < NW; w++) begin
            m_act[w]  = (w == 0);
            m_pc[w]   = (w == 0) ? SPC : 32'd0;
            m_mask[w] = (w == 0) ? NT'(1) : '0;
            m_pend[w] = 0;
            m_blk[w]  = 0;
        end
        m_ov = '0; m_opc = 0; m_ow = 0; m_last = 0; m_ebk = 0;
    endtask

    task automatic model_edge();
        bit            kill, any, issue;
        int            sel, d, b;
        logic [31:0]   pc0[NW];
        logic [NT-1:0] mk0[NW];
        kill = in_dec_valid && in_ebreak;
        any = 0; sel = 0;
        for (int k = 1; k <= NW; k++) begin
            int w = (m_last + k) % NW;
            if (!any && m_act[w] && !m_pend[w] && !m_blk[w] && !m_ebk) begin
                any = 1; sel = w;
            end
        end
        pc0 = m_pc; mk0 = m_mask;
        issue = !in_stall && !kill && any;
        d = int'(in_dec_warp_num);
        b = int'(in_br_warp_num);
        if (issue) begin m_pc[sel] = m_pc[sel] + 32'd4; m_pend[sel] = 1; end
        if (in_dec_valid) begin
            m_pend[d] = 0;
            if (in_branch_stall) m_blk[d] = 1;
            if (in_change_mask) begin
                m_mask[d] = in_thread_mask;
                if (in_thread_mask == '0) m_act[d] = 0;
            end
        end
        if (in_br_valid) begin
            m_blk[b] = 0;
            if (in_br_taken) m_pc[b] = in_br_dest;
        end
        if (in_dec_valid && in_wspawn)
            for (int w = 0; w < NW; w++)
                if (w != d) begin
                    m_act[w] = 1; m_pc[w] = in_wspawn_pc; m_mask[w] = NT'(1);
                    m_pend[w] = 0; m_blk[w] = 0;
                end
        if (kill) for (int w = 0; w < NW; w++) m_act[w] = 0;
        if (!in_stall) begin
            if (issue) begin m_ov = mk0[sel]; m_opc = pc0[sel]; m_ow = sel; m_last = sel; end
            else m_ov = '0;
        end
        if (kill || m_ebk) m_ov = '0;
        if (kill) m_ebk = 1;
    endtask

    task automatic chk_model();
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        chk("out_PC", out_PC, m_opc);
        chk("out_warp_num", 32'(out_warp_num), 32'(m_ow));
        chk("out_ebreak", 32'(out_ebreak), 32'(m_ebk));
    endtask

    task automatic idle();
        in_stall = 0; in_dec_valid = 0; in_dec_warp_num = '0; in_branch_stall = 0;
        in_change_mask = 0; in_thread_mask = '0; in_wspawn = 0; in_wspawn_pc = 0;
        in_ebreak = 0; in_br_valid = 0; in_br_warp_num = '0; in_br_taken = 0; in_br_dest = 0;
    endtask

    task automatic step();
        @(posedge clk);
        if (!reset) model_reset(); else model_edge();
        #1;
        chk_model();
        idle();
    endtask

    task automatic ack(input int w, input bit bs, input bit cm, input logic [NT-1:0] tm);
        in_dec_valid = 1; in_dec_warp_num = WB'(w); in_branch_stall = bs;
        in_change_mask = cm; in_thread_mask = tm;
    endtask

    task automatic expect_issue(input string tag, input int w, input logic [31:0] pc, input logic [NT-1:0] v);
        chk({tag, "_valid"}, 32'(out_valid), 32'(v));
        chk({tag, "_pc"}, out_PC, pc);
        chk({tag, "_warp"}, 32'(out_warp_num), 32'(w));
    endtask

    initial begin
        int pl[$];
        int bl[$];
        bit alive;
        idle();
        reset = 0;
        model_reset();
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_pc", out_PC, 32'd0);
        chk("rst_ebreak", 32'(out_ebreak), 32'd0);
        step(); step();
        reset = 1;

        // basic single-warp issue, acked every issue
        step(); expect_issue("t1_first", 0, SPC, 4'b0001);
        for (int i = 1; i < 3; i++) begin
            ack(0, 0, 0, '0); step();
            chk("t1_bubble", 32'(out_valid), 32'd0);
            step(); expect_issue("t1_seq", 0, SPC + 32'(4 * i), 4'b0001);
        end

        // branch stall, taken then not-taken resolution
        ack(0, 1, 0, '0); step(); step(); step();
        chk("t2_blocked", 32'(out_valid), 32'd0);
        in_br_valid = 1; in_br_warp_num = 0; in_br_taken = 1; in_br_dest = 32'h80000100;
        step(); step(); expect_issue("t2_taken", 0, 32'h80000100, 4'b0001);
        ack(0, 1, 0, '0); step();
        in_br_valid = 1; in_br_warp_num = 0; in_br_taken = 0; in_br_dest = 32'h12345678;
        step(); step(); expect_issue("t2_ntaken", 0, 32'h80000104, 4'b0001);

        // stall freezes outputs and PC
        ack(0, 0, 0, '0); step(); step(); expect_issue("t5_pre", 0, 32'h80000108, 4'b0001);
        ack(0, 0, 0, '0); in_stall = 1; step();
        for (int i = 0; i < 2; i++) begin in_stall = 1; step(); end
        expect_issue("t5_frozen", 0, 32'h80000108, 4'b0001);
        step(); expect_issue("t5_resume", 0, 32'h8000010C, 4'b0001);

        // full thread mask
        ack(0, 0, 1, 4'b1111); step(); step();
        expect_issue("t4_mask", 0, 32'h80000110, 4'b1111);

        // spawn: round robin 1,2,3,0
        ack(0, 0, 0, '0); in_wspawn = 1; in_wspawn_pc = 32'h80000200; step();
        for (int w = 1; w < NW; w++) begin
            step(); expect_issue("t3_spawn", w, 32'h80000200, 4'b0001);
        end
        step(); expect_issue("t3_wrap", 0, 32'h80000114, 4'b1111);
        step(); chk("t3_allpend", 32'(out_valid), 32'd0);

        // ebreak from warp 2
        ack(1, 0, 0, '0); step();
        ack(2, 0, 0, '0); in_ebreak = 1; step();
        chk("t6_ebreak", 32'(out_ebreak), 32'd1);
        chk("t6_novalid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 3; i++) step();
        chk("t6_sticky", 32'(out_ebreak), 32'd1);

        // reset out of ebreak, then asynchronous reset mid-stream
        reset = 0; step(); reset = 1;
        step(); expect_issue("t6_restart", 0, SPC, 4'b0001);
        ack(0, 0, 0, '0); step(); step();
        expect_issue("t6_run", 0, SPC + 32'd4, 4'b0001);
        reset = 0; model_reset(); #1;
        chk_model();
        chk("t6_async_valid", 32'(out_valid), 32'd0);
        chk("t6_async_pc", out_PC, 32'd0);
        step(); reset = 1;
        step(); expect_issue("t6_again", 0, SPC, 4'b0001);

        // randomized traffic
        for (int c = 0; c < 500; c++) begin
            alive = 0;
            for (int w = 0; w < NW; w++) if (m_act[w] || m_pend[w]) alive = 1;
            if (!alive) begin reset = 0; step(); reset = 1; continue; end
            pl.delete(); bl.delete();
            for (int w = 0; w < NW; w++) begin
                if (m_pend[w]) pl.push_back(w);
                if (m_blk[w]) bl.push_back(w);
            end
            in_stall = ($urandom_range(0, 3) == 0);
            if (pl.size() > 0 && $urandom_range(0, 1) == 1) begin
                ack(pl[$urandom_range(0, pl.size() - 1)], $urandom_range(0, 2) == 0,
                    $urandom_range(0, 6) == 0, NT'($urandom_range(0, 15)));
                in_wspawn = ($urandom_range(0, 15) == 0);
                in_wspawn_pc = SPC + ($urandom_range(0, 255) << 2);
            end
            if (bl.size() > 0 && $urandom_range(0, 4) < 2) begin
                in_br_valid = 1; in_br_warp_num = WB'(bl[$urandom_range(0, bl.size() - 1)]);
            end else if ($urandom_range(0, 19) == 0) begin
                in_br_valid = 1; in_br_warp_num = WB'($urandom_range(0, NW - 1));
            end
            in_br_taken = $urandom_range(0, 1) == 1;
            in_br_dest  = SPC + ($urandom_range(0, 1023) << 2);
            step();
        end

        // zero mask on the only warp: nothing ever issues again
        reset = 0; step(); reset = 1;
        step(); expect_issue("t4b_first", 0, SPC, 4'b0001);
        ack(0, 0, 1, 4'b0000); step();
        for (int i = 0; i < 8; i++) step();
        chk("t4b_dead", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
